// File: rtl/echo_pkg.sv
// echo_pkg: shared types and defaults for the echo_sequencer slice.
//   state_t               sequencer FSM states
//   SAMPLE_W              default sample width
//   DEFAULT_SAMPLE_PERIOD clk cycles per sample tick (50 MHz / ~44.1 kHz)
//   DEFAULT_TIMEOUT       wait-state bound used when ECHO_SEQ_TIMEOUT_EN is defined
package echo_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG       = 3'd1,
    REQ       = 3'd2,
    WAIT_SRC  = 3'd3,
    FEED      = 3'd4,
    WAIT_ECHO = 3'd5
  } state_t;

  localparam int SAMPLE_W              = 16;
  localparam int DEFAULT_SAMPLE_PERIOD = 1134;
  localparam int DEFAULT_TIMEOUT       = 64;

endpackage

// File: rtl/echo_sequencer_timer.sv
// sample_rate_timer: sample-period down-counter.
//   clk     system clock
//   reset   synchronous, active-low reset
//   enable  1 = count; 0 = hold at SAMPLE_PERIOD-1
//   tick    1-cycle pulse when the count reaches 0 (counter reloads on that edge)
module sample_rate_timer
  import echo_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= RELOAD;
    end else if (!enable || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // Terminal count only counts as a tick while running, so a disabled timer never fires.
  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/echo_sequencer.sv
// echo_sequencer: paces sine_reader -> echo sample transfers and forwards delay/gain
// step requests to echo only between samples.
//   clk, reset                   system clock, synchronous active-low reset
//   enable                       run sample ticks (0 = finish current sample, then idle)
//   btn_delay, btn_gain          step request pulses
//   generate_next / src_ready / src_sample    sine_reader handshake
//   echo_in / echo_in_ready / echo_ready / echo_out   echo handshake
//   next_D, next_H               echo config step pulses
//   sample_out, sample_valid     last completed output sample and its update strobe
//   overrun                      sticky: tick arrived while one was already pending
//   timeout_err                  sticky wait timeout
// Optional feature: define ECHO_SEQ_TIMEOUT_EN to bound WAIT_SRC/WAIT_ECHO by TIMEOUT
// cycles; without it the waits are unbounded and timeout_err is tied 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | between samples; start a sample or issue a config pulse
// CFG       | one next_D or next_H pulse is on the outputs
// REQ       | generate_next is on the outputs
// WAIT_SRC  | waiting for sine_reader src_ready
// FEED      | echo_in_ready is on the outputs, echo_in stable
// WAIT_ECHO | waiting for echo out_ready
module echo_sequencer
  import echo_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT,
  parameter int WIDTH         = SAMPLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             btn_delay,
  input  logic             btn_gain,
  output logic             generate_next,
  input  logic             src_ready,
  input  logic [WIDTH-1:0] src_sample,
  output logic [WIDTH-1:0] echo_in,
  output logic             echo_in_ready,
  output logic             next_D,
  output logic             next_H,
  input  logic             echo_ready,
  input  logic [WIDTH-1:0] echo_out,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             overrun,
  output logic             timeout_err
);

  if (SAMPLE_PERIOD < 8 || TIMEOUT < 2) begin : g_param_check
    $error("echo_sequencer: SAMPLE_PERIOD must be >= 8 and TIMEOUT >= 2");
  end

  logic tick;

  sample_rate_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  state_t           state, state_nx;
  logic             tick_pend, tick_pend_nx;
  logic             pend_d, pend_d_nx;
  logic             pend_h, pend_h_nx;
  logic             gen_nx, ein_rdy_nx, nd_nx, nh_nx, sv_nx, ovr_nx;
  logic [WIDTH-1:0] echo_in_nx, sample_out_nx;

`ifdef ECHO_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(TIMEOUT - 1);
  logic [WW-1:0] wait_cnt, wait_cnt_nx;
  logic          timeout_err_nx;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      tick_pend     <= 1'b0;
      pend_d        <= 1'b0;
      pend_h        <= 1'b0;
      generate_next <= 1'b0;
      echo_in_ready <= 1'b0;
      next_D        <= 1'b0;
      next_H        <= 1'b0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      echo_in       <= '0;
      sample_out    <= '0;
`ifdef ECHO_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      tick_pend     <= tick_pend_nx;
      pend_d        <= pend_d_nx;
      pend_h        <= pend_h_nx;
      generate_next <= gen_nx;
      echo_in_ready <= ein_rdy_nx;
      next_D        <= nd_nx;
      next_H        <= nh_nx;
      sample_valid  <= sv_nx;
      overrun       <= ovr_nx;
      echo_in       <= echo_in_nx;
      sample_out    <= sample_out_nx;
`ifdef ECHO_SEQ_TIMEOUT_EN
      wait_cnt      <= wait_cnt_nx;
      timeout_err   <= timeout_err_nx;
`endif
    end
  end

`ifndef ECHO_SEQ_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  // All strobes are decided on the transition into their state and registered, so each
  // output is high exactly for the one cycle spent in CFG / REQ / FEED or right after
  // the echo handshake.
  always_comb begin
    state_nx      = state;
    tick_pend_nx  = tick_pend | tick;
    pend_d_nx     = pend_d | btn_delay;
    pend_h_nx     = pend_h | btn_gain;
    ovr_nx        = overrun | (tick & tick_pend);
    gen_nx        = 1'b0;
    ein_rdy_nx    = 1'b0;
    nd_nx         = 1'b0;
    nh_nx         = 1'b0;
    sv_nx         = 1'b0;
    echo_in_nx    = echo_in;
    sample_out_nx = sample_out;
`ifdef ECHO_SEQ_TIMEOUT_EN
    wait_cnt_nx    = wait_cnt;
    timeout_err_nx = timeout_err;
`endif
    case (state)
      IDLE: begin
        // A left-over pending tick only starts a sample while still enabled.
        if (tick || (tick_pend && enable)) begin
          state_nx     = REQ;
          gen_nx       = 1'b1;
          tick_pend_nx = 1'b0;
        end else if (pend_d) begin
          state_nx  = CFG;
          nd_nx     = 1'b1;
          pend_d_nx = btn_delay;
        end else if (pend_h) begin
          state_nx  = CFG;
          nh_nx     = 1'b1;
          pend_h_nx = btn_gain;
        end
      end
      CFG: state_nx = IDLE;
      REQ: begin
        state_nx = WAIT_SRC;
`ifdef ECHO_SEQ_TIMEOUT_EN
        wait_cnt_nx = WAIT_LOAD;
`endif
      end
      WAIT_SRC: begin
        if (src_ready) begin
          state_nx   = FEED;
          echo_in_nx = src_sample;
          ein_rdy_nx = 1'b1;
        end
`ifdef ECHO_SEQ_TIMEOUT_EN
        else if (wait_cnt == '0) begin
          state_nx       = IDLE;
          timeout_err_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt - WW'(1);
        end
`endif
      end
      FEED: begin
        state_nx = WAIT_ECHO;
`ifdef ECHO_SEQ_TIMEOUT_EN
        wait_cnt_nx = WAIT_LOAD;
`endif
      end
      WAIT_ECHO: begin
        if (echo_ready) begin
          state_nx      = IDLE;
          sample_out_nx = echo_out;
          sv_nx         = 1'b1;
        end
`ifdef ECHO_SEQ_TIMEOUT_EN
        else if (wait_cnt == '0) begin
          state_nx       = IDLE;
          timeout_err_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt - WW'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
